bus_bridge: RTL and testbench

- Sits directly downstream of the pipelined CPU's MEM-stage bus port (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata).
- Decodes each access to either data RAM or memory-mapped peripherals.
- Owns the peripheral state: LED register, synchronized switches, 8-digit 7-segment scanner, and a free-running prescaled timer.
- Read data is returned combinationally in the same cycle, because the CPU captures Bus_rdata into its MEM/WB register at the next edge.

---
 rtl/bus_bridge_if.sv | 22 ++
 rtl/bus_bridge.sv | 192 +++++++++++++++++++
 tb/tb_bus_bridge.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_bridge_if.sv
// CPU MEM-stage bus between the pipeline and the bus bridge.
// Read data returns combinationally in the access cycle.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/bus_bridge.sv
// MEM-stage bus decoder: data RAM plus LED, switch,
// 7-segment scanner and prescaled timer peripherals.
module bus_bridge #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic [31:0] TICK_DIV = 32'd25000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  bus_bridge_if.slave bus,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  logic [9:0] woff;
  logic       periph;
  logic       sel_dig;
  logic       sel_tmr;
  logic       sel_led;
  logic       sel_sw;
  logic       wr_dig;
  logic       wr_tmr;
  logic       wr_led;

  logic [23:0] led_q, led_d;
  logic [31:0] dig_q, dig_d;
  logic [23:0] sw_meta_q;
  logic [23:0] sw_sync_q;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        scan_last;
  logic [7:0]  dig_en_q;
  logic [7:0]  dig_seg_q, seg_d;
  logic [3:0]  nib;

  logic [31:0] timer_q, timer_d;
  logic [31:0] presc_q, presc_d;
  logic        tick;

  // Byte offset bits are deliberately ignored by every decode.
  logic unused_lane;
  assign unused_lane = &{1'b0, bus.Bus_addr[1:0]};

  assign periph  = bus.Bus_addr[31:12] == 20'hFFFFF;
  assign woff    = bus.Bus_addr[11:2];
  assign sel_dig = periph && (woff == 10'h000);
  assign sel_tmr = periph && (woff == 10'h008);
  assign sel_led = periph && (woff == 10'h018);
  assign sel_sw  = periph && (woff == 10'h01C);

  assign wr_dig = bus.Bus_wen & sel_dig;
  assign wr_tmr = bus.Bus_wen & sel_tmr;
  assign wr_led = bus.Bus_wen & sel_led;

  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_wen   = bus.Bus_wen & ~periph;
  assign dram_wdata = bus.Bus_wdata;

  assign led     = led_q;
  assign dig_en  = dig_en_q;
  assign dig_seg = dig_seg_q;

  // Same-cycle read mux; the CPU latches it at the next edge.
  always_comb begin
    bus.Bus_rdata = 32'h0;
    unique case (1'b1)
      !periph: bus.Bus_rdata = dram_rdata;
      sel_dig: bus.Bus_rdata = dig_q;
      sel_tmr: bus.Bus_rdata = timer_q;
      sel_led: bus.Bus_rdata = {8'h0, led_q};
      sel_sw:  bus.Bus_rdata = {8'h0, sw_sync_q};
      default: bus.Bus_rdata = 32'h0;
    endcase
  end

  // Next-state for the writable display and LED registers.
  always_comb begin
    led_d = led_q;
    dig_d = dig_q;
    if (wr_led) led_d = bus.Bus_wdata[23:0];
    if (wr_dig) dig_d = bus.Bus_wdata;
  end

  // Register updates; reset overrides a same-cycle write.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      led_q <= 24'h0;
      dig_q <= 32'h0;
    end else begin
      led_q <= led_d;
      dig_q <= dig_d;
    end
  end

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      sw_meta_q <= 24'h0;
      sw_sync_q <= 24'h0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign scan_last = scan_cnt_q == (SCAN_DIV - 16'd1);

  // Scan step counter and digit index with 7 -> 0 wrap.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    idx_d      = idx_q;
    if (scan_last) begin
      scan_cnt_d = 16'h0;
      idx_d      = idx_q + 3'd1;
    end
  end

  // Nibble taken from next-state data so a DIG write shows promptly.
  assign nib = dig_d[{idx_q, 2'b00} +: 4];

  // Active-low hex glyphs with the decimal point kept dark.
  always_comb begin
    seg_d = 8'hC0;
    unique case (nib)
      4'h0: seg_d = 8'hC0;
      4'h1: seg_d = 8'hF9;
      4'h2: seg_d = 8'hA4;
      4'h3: seg_d = 8'hB0;
      4'h4: seg_d = 8'h99;
      4'h5: seg_d = 8'h92;
      4'h6: seg_d = 8'h82;
      4'h7: seg_d = 8'hF8;
      4'h8: seg_d = 8'h80;
      4'h9: seg_d = 8'h90;
      4'hA: seg_d = 8'h88;
      4'hB: seg_d = 8'h83;
      4'hC: seg_d = 8'hC6;
      4'hD: seg_d = 8'hA1;
      4'hE: seg_d = 8'h86;
      4'hF: seg_d = 8'h8E;
      default: seg_d = 8'hC0;
    endcase
  end

  // Scanner state and registered digit/segment drive.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      scan_cnt_q <= 16'h0;
      idx_q      <= 3'd0;
      dig_en_q   <= 8'hFE;
      dig_seg_q  <= 8'hC0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      dig_en_q   <= ~(8'd1 << idx_q);
      dig_seg_q  <= seg_d;
    end
  end

  assign tick = presc_q == (TICK_DIV - 32'd1);

  // Timer next-state; a load beats a coincident tick.
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q + 32'd1;
    if (wr_tmr) begin
      timer_d = bus.Bus_wdata;
      presc_d = 32'h0;
    end else if (tick) begin
      timer_d = timer_q + 32'd1;
      presc_d = 32'h0;
    end
  end

  // Timer and prescaler registers.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      timer_q <= 32'h0;
      presc_q <= 32'h0;
    end else begin
      timer_q <= timer_d;
      presc_q <= presc_d;
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Randomized self-checking bench for bus_bridge.
// Reference model is cycle-count arithmetic plus shadow registers.
module tb_bus_bridge;

  localparam int SD = 2;
  localparam int TD = 3;

  localparam logic [31:0] DIG_A = 32'hFFFF_F000;
  localparam logic [31:0] TMR_A = 32'hFFFF_F020;
  localparam logic [31:0] LED_A = 32'hFFFF_F060;
  localparam logic [31:0] SW_A  = 32'hFFFF_F070;

  logic        cpu_clk;
  logic        cpu_rst;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  bus_bridge_if bus_if ();

  bus_bridge #(
    .SCAN_DIV(16'(SD)),
    .TICK_DIV(32'(TD))
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .bus       (bus_if.slave),
    .dram_addr (dram_addr),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [31:0] ram [0:16383];
  logic [31:0] exp_ram [0:63];
  logic [23:0] exp_led;
  logic [31:0] exp_dig;
  int          dig_wcyc;
  logic [31:0] t_base;
  int          t_cyc;

  initial cpu_clk = 1'b0;
  always #10 cpu_clk = ~cpu_clk;

  // Combinational data RAM driven by the DUT's RAM port.
  assign dram_rdata = ram[dram_addr];
  always @(posedge cpu_clk) if (dram_wen) ram[dram_addr] <= dram_wdata;

  // Edges since the last reset edge.
  always @(posedge cpu_clk) cyc <= cpu_rst ? cyc + 1 : 0;

  function automatic logic [7:0] hexseg(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic int idx_at(input int k);
    return (k / SD) % 8;
  endfunction

  function automatic logic [7:0] exp_en(input int k);
    logic [7:0] one;
    one = 8'd1;
    if (k == 0) return 8'hFE;
    return ~(one << idx_at(k - 1));
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    logic [31:0] v;
    v = exp_dig >> (4 * idx_at(k - 1));
    return hexseg(v[3:0]);
  endfunction

  function automatic logic [31:0] exp_tmr();
    return t_base + 32'((cyc - t_cyc) / TD);
  endfunction

  task automatic drive(input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    bus_if.Bus_addr  = a;
    bus_if.Bus_wen   = w;
    bus_if.Bus_wdata = d;
  endtask

  task automatic clk1();
    @(posedge cpu_clk);
    #2;
    bus_if.Bus_wen = 1'b0;
  endtask

  task automatic model_reset();
    exp_led  = 24'h0;
    exp_dig  = 32'h0;
    dig_wcyc = 0;
    t_base   = 32'h0;
    t_cyc    = 0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    repeat (3) clk1();
    model_reset();
    vecs++;
    if (led !== 24'h0) begin
      errs++; $display("FAIL rst_led got %h exp 000000", led);
    end
    vecs++;
    if (dig_en !== 8'hFE) begin
      errs++; $display("FAIL rst_dig_en got %h exp FE", dig_en);
    end
    vecs++;
    if (dig_seg !== 8'hC0) begin
      errs++; $display("FAIL rst_dig_seg got %h exp C0", dig_seg);
    end
    drive(TMR_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== 32'h0) begin
      errs++; $display("FAIL rst_timer got %h exp 0", bus_if.Bus_rdata);
    end
    drive(DIG_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== 32'h0) begin
      errs++; $display("FAIL rst_dig got %h exp 0", bus_if.Bus_rdata);
    end
    cpu_rst = 1'b1;
    repeat (3) clk1();
    drive(TMR_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== exp_tmr()) begin
      errs++;
      $display("FAIL post_rst_timer got %h exp %h", bus_if.Bus_rdata, exp_tmr());
    end
    vecs++;
    if (dig_en !== exp_en(cyc)) begin
      errs++; $display("FAIL post_rst_en got %h exp %h", dig_en, exp_en(cyc));
    end
  endtask

  task automatic test_led_dram();
    logic [31:0] a, d, oth [7];
    int op, w;
    oth = '{32'hFFFF_F004, 32'hFFFF_F010, 32'hFFFF_F024, 32'hFFFF_F064,
            32'hFFFF_F074, 32'hFFFF_F800, 32'hFFFF_FFFC};
    drive(LED_A, 1'b1, 32'h0000_0123); #1;
    vecs++;
    if (dram_wen !== 1'b0) begin
      errs++; $display("FAIL led_wr_dram_wen got %b exp 0", dram_wen);
    end
    clk1();
    exp_led = 24'h000123;
    drive(LED_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== 32'h0000_0123) begin
      errs++; $display("FAIL led_rd got %h exp 00000123", bus_if.Bus_rdata);
    end
    vecs++;
    if (led !== 24'h000123) begin
      errs++; $display("FAIL led_port got %h exp 000123", led);
    end
    drive(32'h0000_0010, 1'b1, 32'h0000_1234); #1;
    vecs++;
    if (dram_wen !== 1'b1 || dram_addr !== 14'd4 || dram_wdata !== 32'h1234) begin
      errs++;
      $display("FAIL dram_wr got wen=%b addr=%h data=%h exp 1/0004/00001234",
               dram_wen, dram_addr, dram_wdata);
    end
    clk1();
    exp_ram[4] = 32'h1234;
    drive(32'h0000_0010, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== 32'h1234) begin
      errs++; $display("FAIL dram_rd got %h exp 00001234", bus_if.Bus_rdata);
    end
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 4);
      d  = $urandom;
      w  = $urandom_range(0, 63);
      a  = {16'($urandom_range(0, 16'hFFFE)), 8'h0, 6'(w), 2'($urandom)};
      case (op)
        0: begin drive(LED_A | 32'($urandom_range(0, 3)), 1'b1, d); exp_led = d[23:0]; end
        1: begin drive(a, 1'b1, d); exp_ram[w] = d; end
        2: drive(oth[$urandom_range(0, 6)], 1'b1, d);
        3: drive(SW_A, 1'b1, d);
        default: drive(a, 1'b0, d);
      endcase
      #1;
      vecs++;
      if (dram_wen !== (op == 1)) begin
        errs++; $display("FAIL rnd_dram_wen op=%0d got %b", op, dram_wen);
      end
      if (op == 1) begin
        vecs++;
        if (dram_addr !== 14'(w) || dram_wdata !== d) begin
          errs++;
          $display("FAIL rnd_dram_port got %h/%h exp %h/%h", dram_addr, dram_wdata, 14'(w), d);
        end
      end
      clk1();
      drive(LED_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== {8'h0, exp_led} || led !== exp_led) begin
        errs++;
        $display("FAIL rnd_led got %h/%h exp %h", bus_if.Bus_rdata, led, exp_led);
      end
      w = $urandom_range(0, 63);
      drive({16'($urandom_range(0, 16'hFFFE)), 8'h0, 6'(w), 2'($urandom)}, 1'b0, 32'h0);
      #1;
      vecs++;
      if (bus_if.Bus_rdata !== exp_ram[w]) begin
        errs++;
        $display("FAIL rnd_dram_rd w=%0d got %h exp %h", w, bus_if.Bus_rdata, exp_ram[w]);
      end
      drive(oth[$urandom_range(0, 6)], 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== 32'h0) begin
        errs++; $display("FAIL rnd_unmapped got %h exp 0", bus_if.Bus_rdata);
      end
      drive(DIG_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== exp_dig) begin
        errs++; $display("FAIL rnd_dig_kept got %h exp %h", bus_if.Bus_rdata, exp_dig);
      end
    end
  endtask

  task automatic test_switch();
    logic [23:0] v, prev;
    prev = 24'h0;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 24'hA5A5A5 : 24'($urandom);
      sw = v;
      drive(SW_A, 1'b1, 32'hFFFF_FFFF); #1;
      vecs++;
      if (bus_if.Bus_rdata !== {8'h0, prev}) begin
        errs++; $display("FAIL sw_edge0 got %h exp %h", bus_if.Bus_rdata, prev);
      end
      clk1();
      drive(SW_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== {8'h0, prev}) begin
        errs++; $display("FAIL sw_edge1 got %h exp %h", bus_if.Bus_rdata, prev);
      end
      clk1();
      drive(SW_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== {8'h0, v}) begin
        errs++; $display("FAIL sw_edge2 got %h exp %h", bus_if.Bus_rdata, v);
      end
      prev = v;
    end
  endtask

  task automatic test_scan();
    for (int r = 0; r < 3; r++) begin
      drive(DIG_A, 1'b1, (r == 0) ? 32'h89AB_CDEF : $urandom);
      exp_dig = bus_if.Bus_wdata;
      clk1();
      dig_wcyc = cyc;
      drive(DIG_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== exp_dig) begin
        errs++; $display("FAIL dig_rd got %h exp %h", bus_if.Bus_rdata, exp_dig);
      end
      for (int i = 0; i < 20; i++) begin
        clk1();
        vecs++;
        if (dig_en !== exp_en(cyc)) begin
          errs++;
          $display("FAIL scan_en cyc=%0d got %h exp %h", cyc, dig_en, exp_en(cyc));
        end
        if (cyc > dig_wcyc) begin
          vecs++;
          if (dig_seg !== exp_seg(cyc)) begin
            errs++;
            $display("FAIL scan_seg cyc=%0d got %h exp %h", cyc, dig_seg, exp_seg(cyc));
          end
        end
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    drive(TMR_A, 1'b1, 32'hFFFF_FFFE);
    clk1();
    t_base = 32'hFFFF_FFFE;
    t_cyc  = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(TMR_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== exp_tmr()) begin
        errs++;
        $display("FAIL tmr_wrap i=%0d got %h exp %h", i, bus_if.Bus_rdata, exp_tmr());
      end
      clk1();
    end
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 5 && ((cyc - t_cyc) % TD) != TD - 1; b++) clk1();
      v = (r == 0) ? 32'd5 : $urandom;
      drive(TMR_A, 1'b1, v);
      clk1();
      t_base = v;
      t_cyc  = cyc;
      drive(TMR_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== v) begin
        errs++; $display("FAIL tmr_tick_load got %h exp %h", bus_if.Bus_rdata, v);
      end
      repeat ($urandom_range(1, 7)) clk1();
      drive(TMR_A, 1'b0, 32'h0); #1;
      vecs++;
      if (bus_if.Bus_rdata !== exp_tmr()) begin
        errs++; $display("FAIL tmr_run got %h exp %h", bus_if.Bus_rdata, exp_tmr());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dl, dd, dt;
    dl = $urandom;
    dd = $urandom;
    dt = $urandom;
    drive(LED_A, 1'b1, dl);
    clk1();
    drive(DIG_A, 1'b1, dd);
    clk1();
    drive(TMR_A, 1'b1, dt);
    clk1();
    exp_led = dl[23:0];
    exp_dig = dd;
    t_base  = dt;
    t_cyc   = cyc;
    drive(LED_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== {8'h0, exp_led}) begin
      errs++; $display("FAIL b2b_led got %h exp %h", bus_if.Bus_rdata, exp_led);
    end
    drive(DIG_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== exp_dig) begin
      errs++; $display("FAIL b2b_dig got %h exp %h", bus_if.Bus_rdata, exp_dig);
    end
    drive(TMR_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== exp_tmr()) begin
      errs++; $display("FAIL b2b_tmr got %h exp %h", bus_if.Bus_rdata, exp_tmr());
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) clk1();
    cpu_rst = 1'b0;
    drive(LED_A, 1'b1, 32'h0000_00FF);
    clk1();
    model_reset();
    vecs++;
    if (led !== 24'h0) begin
      errs++; $display("FAIL mid_rst_led got %h exp 000000", led);
    end
    vecs++;
    if (dig_en !== 8'hFE) begin
      errs++; $display("FAIL mid_rst_en got %h exp FE", dig_en);
    end
    drive(TMR_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== 32'h0) begin
      errs++; $display("FAIL mid_rst_tmr got %h exp 0", bus_if.Bus_rdata);
    end
    cpu_rst = 1'b1;
    repeat (4) clk1();
    drive(TMR_A, 1'b0, 32'h0); #1;
    vecs++;
    if (bus_if.Bus_rdata !== exp_tmr() || dig_en !== exp_en(cyc)) begin
      errs++;
      $display("FAIL mid_rst_resume got %h/%h exp %h/%h",
               bus_if.Bus_rdata, dig_en, exp_tmr(), exp_en(cyc));
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    for (int i = 0; i < 64; i++) exp_ram[i] = 32'h0;
    sw = 24'h0;
    cpu_rst = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    model_reset();
    test_reset();
    test_led_dram();
    test_switch();
    test_scan();
    test_timer();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
